magic_nmi_arbiter: RTL and testbench

MAGIC_NMI_ARBITER -- requirements
Module: magic_nmi_arbiter

---
 rtl/magic_nmi_arbiter.sv | 135 +++++++++++++
 tb/tb_magic_nmi_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/magic_nmi_arbiter.sv
// rtl/magic_nmi_arbiter.sv - debounced button NMI arbiter with ULA-synchronised assertion and ack timeout
module magic_nmi_arbiter #(
   parameter int DEBOUNCE_W = 16,
   parameter int TIMEOUT_W  = 20
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic        btn_magic,
   input  logic        btn_pause,
   input  logic        btn_div,
   input  logic        n_int,
   input  logic        n_int_next,
   input  logic        bus_m1,
   input  logic        bus_mreq,
   input  logic [15:0] bus_a,
   input  logic        magic_mode,
   input  logic        div_en,
   output logic        n_nmi,
   output logic [1:0]  nmi_src,
   output logic        nmi_timeout,
   output logic        magic_button,
   output logic        pause_button,
   output logic        div_button
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_INT, S_ASSERT, S_HOLDOFF} state_t;

   // Button lanes: bit 0 magic, bit 1 div, bit 2 pause.
   logic [2:0]            w_raw;
   logic [2:0]            r_sync1;
   logic [2:0]            r_sync2;
   logic [2:0]            r_stable;
   logic [2:0]            r_stable_d;
   logic [DEBOUNCE_W-1:0] r_db_cnt [3];

   state_t                r_state;
   logic [TIMEOUT_W-1:0]  r_to_cnt;
   logic [TIMEOUT_W-1:0]  w_to_next;
   logic [2:0]            w_rise;
   logic                  w_req_magic;
   logic                  w_req_div;
   logic                  w_req_pause;
   logic                  w_ack;
   logic                  w_to_hit;

   assign w_raw = {btn_pause, btn_div, btn_magic};

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_stable   <= '0;
         r_stable_d <= '0;
         for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1    <= w_raw;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == {DEBOUNCE_W{1'b1}}) begin
               r_stable[i] <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_rise      = r_stable & ~r_stable_d;
   assign w_req_magic = w_rise[0] & ~magic_mode;
   assign w_req_div   = w_rise[1] & div_en;
   assign w_req_pause = w_rise[2] & ~magic_mode;
   assign w_ack       = bus_m1 & bus_mreq & (bus_a == 16'h0066);
   assign w_to_next   = r_to_cnt + 1'b1;
   // The NMI stays low for 2^TIMEOUT_W-1 cycles before giving up.
   assign w_to_hit    = (w_to_next == {TIMEOUT_W{1'b1}});

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_to_cnt    <= '0;
         n_nmi       <= 1'b1;
         nmi_src     <= 2'd0;
         nmi_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_magic) begin
                  nmi_src <= 2'd1;
                  r_state <= S_WAIT_INT;
               end else if (w_req_div) begin
                  nmi_src <= 2'd2;
                  r_state <= S_WAIT_INT;
               end else if (w_req_pause) begin
                  nmi_src <= 2'd3;
                  r_state <= S_WAIT_INT;
               end
            end
            S_WAIT_INT: begin
               if (n_int && !n_int_next) begin
                  n_nmi   <= 1'b0;
                  r_state <= S_ASSERT;
               end
            end
            S_ASSERT: begin
               if (w_ack) begin
                  n_nmi       <= 1'b1;
                  nmi_timeout <= 1'b0;
                  r_to_cnt    <= '0;
                  r_state     <= S_HOLDOFF;
               end else if (w_to_hit) begin
                  n_nmi       <= 1'b1;
                  nmi_timeout <= 1'b1;
                  r_to_cnt    <= '0;
                  r_state     <= S_HOLDOFF;
               end else begin
                  r_to_cnt <= w_to_next;
               end
            end
            S_HOLDOFF: begin
               if (r_stable == 3'b000) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign magic_button = r_stable[0];
   assign div_button   = r_stable[1];
   assign pause_button = r_stable[2];

endmodule

// File: tb/tb_magic_nmi_arbiter.sv
// tb/tb_magic_nmi_arbiter.sv - directed self-checking bench for magic_nmi_arbiter
module tb_magic_nmi_arbiter;

   logic        clk28 = 1'b0;
   logic        rst;
   logic        btn_magic, btn_pause, btn_div;
   logic        n_int, n_int_next;
   logic        bus_m1, bus_mreq;
   logic [15:0] bus_a;
   logic        magic_mode, div_en;
   logic        n_nmi;
   logic [1:0]  nmi_src;
   logic        nmi_timeout;
   logic        magic_button, pause_button, div_button;

   int n_checks = 0;
   int n_fail   = 0;

   magic_nmi_arbiter #(.DEBOUNCE_W(3), .TIMEOUT_W(4)) dut (
      .clk28(clk28), .rst(rst),
      .btn_magic(btn_magic), .btn_pause(btn_pause), .btn_div(btn_div),
      .n_int(n_int), .n_int_next(n_int_next),
      .bus_m1(bus_m1), .bus_mreq(bus_mreq), .bus_a(bus_a),
      .magic_mode(magic_mode), .div_en(div_en),
      .n_nmi(n_nmi), .nmi_src(nmi_src), .nmi_timeout(nmi_timeout),
      .magic_button(magic_button), .pause_button(pause_button), .div_button(div_button)
   );

   always #5 clk28 = ~clk28;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk28);
      #1;
   endtask

   task automatic int_edge();
      n_int_next = 1'b0;
      tick(1);
      n_int_next = 1'b1;
   endtask

   task automatic do_ack();
      bus_m1 = 1'b1; bus_mreq = 1'b1; bus_a = 16'h0066;
      tick(1);
      bus_m1 = 1'b0; bus_mreq = 1'b0; bus_a = 16'h0000;
   endtask

   initial begin
      rst = 1'b1;
      btn_magic = 0; btn_pause = 0; btn_div = 0;
      n_int = 1; n_int_next = 1;
      bus_m1 = 0; bus_mreq = 0; bus_a = 16'h0000;
      magic_mode = 0; div_en = 1;
      #12;
      check("rst_n_nmi", {7'd0, n_nmi}, 8'd1);
      check("rst_src", {6'd0, nmi_src}, 8'd0);
      check("rst_timeout", {7'd0, nmi_timeout}, 8'd0);
      check("rst_buttons", {5'd0, magic_button, pause_button, div_button}, 8'd0);
      @(posedge clk28); #1 rst = 1'b0;

      // magic press, ULA edge, acknowledged fetch
      btn_magic = 1;
      tick(9);  check("magic_db_9", {7'd0, magic_button}, 8'd0);
      tick(1);  check("magic_db_10", {7'd0, magic_button}, 8'd1);
      check("magic_src_pre", {6'd0, nmi_src}, 8'd0);
      tick(1);  check("magic_src", {6'd0, nmi_src}, 8'd1);
      check("magic_nmi_wait", {7'd0, n_nmi}, 8'd1);
      int_edge(); check("magic_nmi_low", {7'd0, n_nmi}, 8'd0);
      tick(3);  check("magic_nmi_held", {7'd0, n_nmi}, 8'd0);
      do_ack(); check("magic_nmi_rel", {7'd0, n_nmi}, 8'd1);
      check("magic_timeout", {7'd0, nmi_timeout}, 8'd0);
      btn_magic = 0; tick(12);

      // simultaneous pause+div: div wins, pause dropped
      btn_pause = 1; btn_div = 1;
      tick(11); check("prio_src_div", {6'd0, nmi_src}, 8'd2);
      int_edge(); do_ack();
      btn_pause = 0; btn_div = 0; tick(12);
      check("prio_pause_dropped", {6'd0, nmi_src}, 8'd2);
      btn_pause = 1;
      tick(11); check("pause_src", {6'd0, nmi_src}, 8'd3);
      int_edge(); check("pause_nmi_low", {7'd0, n_nmi}, 8'd0);
      do_ack(); btn_pause = 0; tick(12);

      // unacknowledged NMI times out after 15 cycles
      btn_magic = 1;
      tick(11); check("to_src", {6'd0, nmi_src}, 8'd1);
      int_edge(); check("to_low0", {7'd0, n_nmi}, 8'd0);
      tick(14); check("to_low14", {7'd0, n_nmi}, 8'd0);
      tick(1);  check("to_rel15", {7'd0, n_nmi}, 8'd1);
      check("to_flag", {7'd0, nmi_timeout}, 8'd1);
      btn_magic = 0; tick(12);
      check("to_sticky", {7'd0, nmi_timeout}, 8'd1);
      btn_div = 1;
      tick(11); check("to_div_src", {6'd0, nmi_src}, 8'd2);
      int_edge(); do_ack();
      check("to_cleared", {7'd0, nmi_timeout}, 8'd0);
      btn_div = 0; tick(12);

      // glitch, disabled div, magic_mode masking
      btn_magic = 1; tick(5); btn_magic = 0; tick(12);
      check("glitch_level", {7'd0, magic_button}, 8'd0);
      int_edge(); check("glitch_no_nmi", {7'd0, n_nmi}, 8'd1);
      check("glitch_src", {6'd0, nmi_src}, 8'd2);
      div_en = 0; btn_div = 1; tick(11);
      check("divdis_level", {7'd0, div_button}, 8'd1);
      int_edge(); check("divdis_no_nmi", {7'd0, n_nmi}, 8'd1);
      btn_div = 0; div_en = 1; tick(12);
      magic_mode = 1; btn_magic = 1; tick(11);
      check("mmode_level", {7'd0, magic_button}, 8'd1);
      int_edge(); check("mmode_no_nmi", {7'd0, n_nmi}, 8'd1);
      check("mmode_src", {6'd0, nmi_src}, 8'd2);
      btn_magic = 0; tick(12); magic_mode = 0;

      // reset during ASSERT with button still held
      btn_magic = 1; tick(11);
      int_edge(); check("rstmid_low", {7'd0, n_nmi}, 8'd0);
      #3 rst = 1'b1;
      #1 check("rstmid_nmi", {7'd0, n_nmi}, 8'd1);
      check("rstmid_src", {6'd0, nmi_src}, 8'd0);
      @(posedge clk28); #1 rst = 1'b0;
      tick(9);  check("rstmid_db_9", {7'd0, magic_button}, 8'd0);
      tick(1);  check("rstmid_db_10", {7'd0, magic_button}, 8'd1);
      tick(1);  check("rstmid_src2", {6'd0, nmi_src}, 8'd1);
      check("rstmid_wait", {7'd0, n_nmi}, 8'd1);
      int_edge(); check("rstmid_low2", {7'd0, n_nmi}, 8'd0);
      do_ack(); btn_magic = 0; tick(12);

      // second button during ASSERT / HOLDOFF ignored
      btn_magic = 1; tick(11);
      int_edge(); check("busy_low", {7'd0, n_nmi}, 8'd0);
      btn_div = 1; tick(11);
      check("busy_still_low", {7'd0, n_nmi}, 8'd0);
      check("busy_src", {6'd0, nmi_src}, 8'd1);
      do_ack(); check("busy_rel", {7'd0, n_nmi}, 8'd1);
      btn_magic = 0; tick(12);
      int_edge(); check("holdoff_no_nmi", {7'd0, n_nmi}, 8'd1);
      check("holdoff_src", {6'd0, nmi_src}, 8'd1);
      btn_div = 0; tick(12);
      btn_div = 1; tick(11);
      check("fresh_src", {6'd0, nmi_src}, 8'd2);
      int_edge(); check("fresh_low", {7'd0, n_nmi}, 8'd0);
      do_ack(); btn_div = 0; tick(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
